// File: rtl/ahb_img_mem.sv
// AHB slave image frame memory with single-master bus grant.
// Define AHB_MEM_PROTCHK_EN to build the sticky AHB protocol checker driving O_MEM_PROT_ERR.
module ahb_img_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_W      = 14,
    parameter int          WAIT_STATES = 0
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET_N,
    input  logic        I_MEM_HBUSREQ,
    output logic        O_MEM_HGRANT,
    input  logic [31:0] I_MEM_HADDR,
    input  logic [1:0]  I_MEM_HTRANS,
    input  logic [2:0]  I_MEM_HSIZE,
    input  logic [3:0]  I_MEM_HBURST,
    input  logic        I_MEM_HWRITE,
    input  logic [31:0] I_MEM_HWDATA,
    output logic [31:0] O_MEM_HRDATA,
    output logic        O_MEM_HREADY,
    output logic        O_MEM_HRESP,
    output logic        O_MEM_PROT_ERR
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    localparam int          DEPTH      = 1 << ADDR_W;
    localparam logic [32:0] SPAN       = 33'd1 << (ADDR_W + 2);
    localparam logic [2:0]  WAIT_LOAD  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [2:0]  BEAT_STATE = (WAIT_STATES > 0) ? S_WAIT : S_DONE;

    logic [2:0]        state, wcnt;
    logic              hgrant, d_write;
    logic [ADDR_W-1:0] d_idx, idx;
    logic [3:0]        d_lanes, lanes;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_q, wr_word;
    logic [32:0]       off;
    logic              hready, active, accept, bad, misalign, commit;

    // 33-bit offset: a borrow (address below base) lands far above SPAN.
    always_comb begin
        off      = {1'b0, I_MEM_HADDR} - {1'b0, BASE_ADDR};
        idx      = off[ADDR_W+1:2];
        misalign = (I_MEM_HSIZE == 3'd1 && I_MEM_HADDR[0]) ||
                   (I_MEM_HSIZE == 3'd2 && I_MEM_HADDR[1:0] != 2'b00);
        bad      = (off >= SPAN) || (I_MEM_HSIZE > 3'd2) || misalign;
        case (I_MEM_HSIZE)
            3'd0:    lanes = 4'b0001 << I_MEM_HADDR[1:0];
            3'd1:    lanes = I_MEM_HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    always_comb begin
        wr_word = mem[d_idx];
        for (int b = 0; b < 4; b++)
            if (d_lanes[b]) wr_word[8*b +: 8] = I_MEM_HWDATA[8*b +: 8];
    end

    assign hready = !(state == S_WAIT || state == S_ERR1);
    assign active = I_MEM_HTRANS[1];
    assign accept = hready && state != S_ERR2 && active;
    assign commit = state == S_DONE && d_write;

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state   <= S_IDLE;
            wcnt    <= 3'd0;
            hgrant  <= 1'b0;
            d_write <= 1'b0;
            d_idx   <= '0;
            d_lanes <= 4'b0000;
        end else begin
            hgrant <= I_MEM_HBUSREQ || state != S_IDLE;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state   <= bad ? S_ERR1 : BEAT_STATE;
                        wcnt    <= WAIT_LOAD;
                        d_write <= I_MEM_HWRITE && !bad;
                        d_idx   <= idx;
                        d_lanes <= lanes;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (wcnt == 3'd0) state <= S_DONE;
                    else              wcnt  <= wcnt - 3'd1;
                end
                S_ERR1:  state <= S_ERR2;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read captured at address phase; forward a same-word write completing this cycle.
    always_ff @(posedge I_HCLK) begin
        if (commit) mem[d_idx] <= wr_word;
        if (accept && !bad && !I_MEM_HWRITE)
            rd_q <= (commit && d_idx == idx) ? wr_word : mem[idx];
    end

    assign O_MEM_HGRANT = hgrant;
    assign O_MEM_HREADY = hready;
    assign O_MEM_HRESP  = state == S_ERR1 || state == S_ERR2;
    assign O_MEM_HRDATA = (state == S_DONE && !d_write) ? rd_q : 32'h0;

`ifdef AHB_MEM_PROTCHK_EN
    logic        prot_err, hold_vld, hold_write;
    logic [1:0]  prev_trans, hold_trans;
    logic [31:0] last_addr, hold_addr;
    logic        seq_orphan, seq_addr_bad, hold_bad, no_grant;

    always_comb begin
        seq_orphan   = hready && I_MEM_HTRANS == 2'd3 && prev_trans == 2'd0;
        seq_addr_bad = hready && I_MEM_HTRANS == 2'd3 && prev_trans != 2'd0 &&
                       I_MEM_HADDR != last_addr + (32'd1 << I_MEM_HSIZE);
        hold_bad     = hold_vld && (I_MEM_HADDR != hold_addr ||
                       I_MEM_HTRANS != hold_trans || I_MEM_HWRITE != hold_write);
        no_grant     = hready && active && !hgrant;
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            prot_err   <= 1'b0;
            prev_trans <= 2'd0;
            last_addr  <= 32'h0;
            hold_vld   <= 1'b0;
            hold_addr  <= 32'h0;
            hold_trans <= 2'd0;
            hold_write <= 1'b0;
        end else begin
            prot_err   <= prot_err || seq_orphan || seq_addr_bad || hold_bad || no_grant;
            if (hready) prev_trans <= I_MEM_HTRANS;
            if (hready && active) last_addr <= I_MEM_HADDR;
            hold_vld   <= !hready;
            hold_addr  <= I_MEM_HADDR;
            hold_trans <= I_MEM_HTRANS;
            hold_write <= I_MEM_HWRITE;
        end
    end

    assign O_MEM_PROT_ERR = prot_err;
`else
    assign O_MEM_PROT_ERR = 1'b0;
`endif

    logic unused_burst;
    assign unused_burst = ^I_MEM_HBURST;
endmodule

// File: tb/tb_ahb_img_mem.sv
// Scoreboard bench for ahb_img_mem: one zero-wait and one two-wait instance share the bus stimulus;
// sel picks whose responses the bench follows and checks.
module tb_ahb_img_mem;
    logic        clk = 1'b0;
    logic        rst_n, hbusreq, hwrite, sel;
    logic [31:0] haddr, hwdata, pend_wd;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hburst;
    logic        g0, g1, r0, r1, e0, e1, p0, p1;
    logic [31:0] rd0, rd1;
    logic        hgrant, hready, hresp, prot_err;
    logic [31:0] hrdata;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        int          waits;
        logic        resp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0, wait_cnt = 0;

`ifdef AHB_MEM_PROTCHK_EN
    localparam logic PROT_EXP = 1'b1;
`else
    localparam logic PROT_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    ahb_img_mem #(.BASE_ADDR(32'h0), .ADDR_W(14), .WAIT_STATES(0)) u_dut0 (
        .I_HCLK(clk), .I_HRESET_N(rst_n), .I_MEM_HBUSREQ(hbusreq), .O_MEM_HGRANT(g0),
        .I_MEM_HADDR(haddr), .I_MEM_HTRANS(htrans), .I_MEM_HSIZE(hsize), .I_MEM_HBURST(hburst),
        .I_MEM_HWRITE(hwrite), .I_MEM_HWDATA(hwdata), .O_MEM_HRDATA(rd0), .O_MEM_HREADY(r0),
        .O_MEM_HRESP(e0), .O_MEM_PROT_ERR(p0));

    ahb_img_mem #(.BASE_ADDR(32'h0), .ADDR_W(14), .WAIT_STATES(2)) u_dut1 (
        .I_HCLK(clk), .I_HRESET_N(rst_n), .I_MEM_HBUSREQ(hbusreq), .O_MEM_HGRANT(g1),
        .I_MEM_HADDR(haddr), .I_MEM_HTRANS(htrans), .I_MEM_HSIZE(hsize), .I_MEM_HBURST(hburst),
        .I_MEM_HWRITE(hwrite), .I_MEM_HWDATA(hwdata), .O_MEM_HRDATA(rd1), .O_MEM_HREADY(r1),
        .O_MEM_HRESP(e1), .O_MEM_PROT_ERR(p1));

    assign hgrant   = sel ? g1 : g0;
    assign hready   = sel ? r1 : r0;
    assign hresp    = sel ? e1 : e0;
    assign hrdata   = sel ? rd1 : rd0;
    assign prot_err = sel ? p1 : p0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Data-phase monitor: pops one expectation per completed beat.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            wait_cnt = 0;
        end else if (sb.size() > 0) begin
            if (hready) begin
                e = sb.pop_front();
                chk("beat_waits", wait_cnt, e.waits);
                chk("beat_hresp", hresp, e.resp);
                chk("beat_hrdata", hrdata, (e.wr || e.resp) ? 32'h0 : e.rdata);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                chk("wait_hresp", hresp, sb[0].resp);
                chk("wait_hrdata", hrdata, 0);
            end
        end else begin
            chk("idle_bus", {hready, hresp, hrdata}, {1'b1, 1'b0, 32'h0});
        end
    end

    // Present one address phase (and the previous beat's HWDATA), wait until it is sampled.
    task automatic xfer(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [31:0] rd_exp, input logic err);
        logic rdy;
        int   n;
        exp_t e;
        hwdata = pend_wd; htrans = tr; hwrite = wr; haddr = a; hsize = sz;
        rdy = 1'b0; n = 0;
        while (!rdy && n < 64) begin
            @(negedge clk); rdy = hready; @(posedge clk); n++;
        end
        if (!rdy) chk("xfer_timeout", 0, 1);
        if (tr[1]) begin
            e.wr = wr; e.rdata = rd_exp; e.resp = err; e.waits = err ? 1 : (sel ? 2 : 0);
            sb.push_back(e);
        end
        pend_wd = wd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) xfer(2'd0, 1'b0, 32'h0, 3'd2, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; hbusreq = 1'b0; sel = 1'b0; haddr = 32'h0; htrans = 2'd0; hsize = 3'd2;
        hburst = 4'd0; hwrite = 1'b0; hwdata = 32'h0; pend_wd = 32'h0;

        // reset state, held 3 cycles then released
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", {hgrant, hready, hresp, hrdata}, {1'b0, 1'b1, 1'b0, 32'h0});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_outs", {hgrant, hready, hresp, hrdata}, {1'b0, 1'b1, 1'b0, 32'h0});

        // grant one cycle after request
        @(posedge clk); #1 hbusreq = 1'b1;
        @(negedge clk); chk("grant_lag", hgrant, 0);
        @(negedge clk); chk("grant_rise", hgrant, 1);
        @(posedge clk); #1;

        // word write then pipelined read, zero waits
        xfer(2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer(2'd2, 1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);
        idle(2);

        // byte/halfword lane merge
        xfer(2'd2, 1'b1, 32'h20, 3'd2, 32'h0000_0000, 32'h0, 1'b0);
        xfer(2'd2, 1'b1, 32'h21, 3'd0, 32'h0000_1100, 32'h0, 1'b0);
        xfer(2'd2, 1'b1, 32'h22, 3'd0, 32'h0022_0000, 32'h0, 1'b0);
        xfer(2'd2, 1'b1, 32'h20, 3'd1, 32'h0000_AB00, 32'h0, 1'b0);
        xfer(2'd2, 1'b0, 32'h20, 3'd2, 32'h0, 32'h0022AB00, 1'b0);
        xfer(2'd2, 1'b0, 32'h22, 3'd1, 32'h0, 32'h0022AB00, 1'b0);
        idle(2);

        // top word is valid; one past it and bad size/alignment take the error path
        xfer(2'd2, 1'b1, 32'h0000_FFFC, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0);
        xfer(2'd2, 1'b0, 32'h0000_FFFC, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0);
        xfer(2'd2, 1'b1, 32'h0, 3'd2, 32'h12345678, 32'h0, 1'b0);
        idle(1);
        xfer(2'd2, 1'b1, 32'h0001_0000, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1);
        idle(1);
        xfer(2'd2, 1'b1, 32'h01, 3'd1, 32'hFFFFFFFF, 32'h0, 1'b1);
        idle(1);
        xfer(2'd2, 1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1);
        idle(1);
        xfer(2'd2, 1'b0, 32'h04, 3'd3, 32'h0, 32'h0, 1'b1);
        idle(1);
        xfer(2'd2, 1'b0, 32'h0, 3'd2, 32'h0, 32'h12345678, 1'b0);
        idle(2);

        // read-after-write bypass
        xfer(2'd2, 1'b1, 32'h0, 3'd2, 32'h5A5A5A5A, 32'h0, 1'b0);
        xfer(2'd2, 1'b0, 32'h0, 3'd2, 32'h0, 32'h5A5A5A5A, 1'b0);
        idle(2);
        chk("prot_clean", prot_err, 0);

        // SEQ straight after IDLE
        xfer(2'd3, 1'b0, 32'h0, 3'd2, 32'h0, 32'h5A5A5A5A, 1'b0);
        idle(2);
        chk("prot_set", prot_err, PROT_EXP);
        idle(3);
        chk("prot_sticky", prot_err, PROT_EXP);

        // two wait states: prefill then INCR4 read
        idle(6);
        sel = 1'b1;
        for (int i = 0; i < 4; i++)
            xfer(2'd2, 1'b1, 32'(4 * i), 3'd2, 32'(i + 1), 32'h0, 1'b0);
        hburst = 4'd3;
        for (int i = 0; i < 4; i++)
            xfer((i == 0) ? 2'd2 : 2'd3, 1'b0, 32'(4 * i), 3'd2, 32'h0, 32'(i + 1), 1'b0);
        hburst = 4'd0;
        idle(2);

        // reset during a write's wait states drops the write and raises HREADY at once
        haddr = 32'h4; htrans = 2'd2; hsize = 3'd2; hwrite = 1'b1;
        @(posedge clk); #1;
        begin
            exp_t e;
            e.wr = 1'b1; e.rdata = 32'h0; e.resp = 1'b0; e.waits = 2;
            sb.push_back(e);
        end
        htrans = 2'd0; hwrite = 1'b0; hwdata = 32'hFFFFFFFF;
        @(negedge clk); chk("mid_wait_hready", hready, 0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outs", {hgrant, hready, hresp}, {1'b0, 1'b1, 1'b0});
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1; pend_wd = 32'h0;
        xfer(2'd2, 1'b0, 32'h4, 3'd2, 32'h0, 32'h2, 1'b0);
        idle(2);

        // grant drops one cycle after request goes away
        @(posedge clk); #1 hbusreq = 1'b0;
        @(negedge clk); chk("grant_hold", hgrant, 1);
        @(negedge clk); chk("grant_fall", hgrant, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
